// File: rtl/servo_pkg.sv
// ============================================================================
// Module   : servo_pkg
// Purpose  : Shared timing defaults and FSM encoding for the servo PWM block.
// Revision : 1.0
// ============================================================================
`default_nettype none

package servo_pkg;

  localparam int unsigned c_CLK_HZ        = 100_000_000;
  localparam int unsigned c_PERIOD_CYCLES = 2_000_000;
  localparam int unsigned c_MIN_CYCLES    = 100_000;
  localparam int unsigned c_STEP_CYCLES   = 6_667;
  localparam int unsigned c_MAX_CYCLES    = 200_000;

  localparam int unsigned c_STATE_W = 2;
  typedef logic [c_STATE_W-1:0] state_t;

  localparam state_t c_IDLE = 2'd0;
  localparam state_t c_HIGH = 2'd1;
  localparam state_t c_LOW  = 2'd2;

  // Frame counter width; never below one bit.
  function automatic int unsigned cnt_width(input int unsigned period);
    return (period > 1) ? $clog2(period) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/servo_width_calc.sv
// ============================================================================
// Module   : servo_width_calc
// Purpose  : Maps a 4-bit position to a clamped pulse width in clk cycles.
// Revision : 1.0
// ============================================================================
`default_nettype none

module servo_width_calc
  import servo_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES = c_PERIOD_CYCLES,
  parameter int unsigned MIN_CYCLES    = c_MIN_CYCLES,
  parameter int unsigned STEP_CYCLES   = c_STEP_CYCLES,
  parameter int unsigned MAX_CYCLES    = c_MAX_CYCLES,
  parameter int unsigned CNT_W         = cnt_width(PERIOD_CYCLES)
) (
  input  logic [3:0]       pos,
  output logic [CNT_W-1:0] width
);

  localparam logic [47:0] c_MIN  = 48'(MIN_CYCLES);
  localparam logic [47:0] c_STEP = 48'(STEP_CYCLES);
  localparam logic [47:0] c_MAX  = 48'(MAX_CYCLES);
  localparam logic [47:0] c_LAST = 48'(PERIOD_CYCLES) - 48'd1;

  logic [47:0] w_lim;

  // Wide arithmetic so no parameter combination can overflow before clamping.
  // A zero width is lifted to one: every frame opens with pwm high.
  always_comb begin
    w_lim = c_MIN + ({44'd0, pos} * c_STEP);
    if (w_lim > c_MAX) w_lim = c_MAX;
    if (w_lim > c_LAST) w_lim = c_LAST;
    if (w_lim == 48'd0) w_lim = 48'd1;
    width = CNT_W'(w_lim);
  end

endmodule

`default_nettype wire

// File: rtl/servo_pwm.sv
// ============================================================================
// Module   : servo_pwm
// Purpose  : Hobby-servo PWM frame generator with frame-aligned position update.
// Revision : 1.0
// ============================================================================
`default_nettype none

module servo_pwm
  import servo_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES = c_PERIOD_CYCLES,
  parameter int unsigned MIN_CYCLES    = c_MIN_CYCLES,
  parameter int unsigned STEP_CYCLES   = c_STEP_CYCLES,
  parameter int unsigned MAX_CYCLES    = c_MAX_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [3:0] pos,
  output logic       pwm,
  output logic       frame_tick,
  output logic [3:0] pos_active,
  output logic       busy
);

  localparam int unsigned        c_CNT_W = cnt_width(PERIOD_CYCLES);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(PERIOD_CYCLES - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] r_width;
  logic [c_CNT_W-1:0] w_width;
  logic [c_CNT_W-1:0] w_cnt_inc;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic               w_pulse_end;
  logic               w_frame_end;
  logic               w_start;
  logic               w_pwm_nxt;
  logic               w_busy_nxt;
  logic               r_pwm;
  logic               r_tick;
  logic               r_busy;
  logic [3:0]         r_pos_active;

  servo_width_calc #(
    .PERIOD_CYCLES (PERIOD_CYCLES),
    .MIN_CYCLES    (MIN_CYCLES),
    .STEP_CYCLES   (STEP_CYCLES),
    .MAX_CYCLES    (MAX_CYCLES),
    .CNT_W         (c_CNT_W)
  ) u_width_calc (
    .pos   (pos),
    .width (w_width)
  );

  assign w_cnt_inc   = r_cnt + c_CNT_W'(1);
  assign w_pulse_end = (w_cnt_inc == r_width);
  assign w_frame_end = (r_cnt == c_LAST);

  // Position and width are captured only at frame start, so mid-frame pos
  // changes cannot reshape a pulse already in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= c_IDLE;
      r_cnt        <= '0;
      r_width      <= c_CNT_W'(1);
      r_pwm        <= 1'b0;
      r_tick       <= 1'b0;
      r_busy       <= 1'b0;
      r_pos_active <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pwm   <= w_pwm_nxt;
      r_tick  <= w_start;
      r_busy  <= w_busy_nxt;
      if (w_start) begin
        r_pos_active <= pos;
        r_width      <= w_width;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (run) w_state_nxt = c_HIGH;
      c_HIGH:  if (w_pulse_end) w_state_nxt = c_LOW;
      c_LOW:   if (w_frame_end) w_state_nxt = run ? c_HIGH : c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    w_start    = (w_state_nxt == c_HIGH) && (r_state != c_HIGH);
    w_cnt_nxt  = (w_start || (w_state_nxt == c_IDLE)) ? '0 : w_cnt_inc;
    w_pwm_nxt  = (w_state_nxt == c_HIGH);
    w_busy_nxt = (w_state_nxt != c_IDLE);
  end

  assign pwm        = r_pwm;
  assign frame_tick = r_tick;
  assign busy       = r_busy;
  assign pos_active = r_pos_active;

endmodule

`default_nettype wire

// File: tb/tb_servo_pwm.sv
// ============================================================================
// Module   : tb_servo_pwm
// Purpose  : Self-checking bench for servo_pwm against a frame-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_servo_pwm;

  localparam int P  = 200;
  localparam int MN = 10;
  localparam int ST = 6;
  localparam int MX = 90;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [3:0] pos;
  logic       pwm;
  logic       frame_tick;
  logic [3:0] pos_active;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  servo_pwm #(
    .PERIOD_CYCLES (P),
    .MIN_CYCLES    (MN),
    .STEP_CYCLES   (ST),
    .MAX_CYCLES    (MX)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .pos        (pos),
    .pwm        (pwm),
    .frame_tick (frame_tick),
    .pos_active (pos_active),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_width(input int p);
    int w;
    w = MN + p * ST;
    if (w > MX) w = MX;
    if (w > P - 1) w = P - 1;
    if (w < 1) w = 1;
    return w;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s timeout t=%0t", name, $time);
  endtask

  // Frame-level model: a frame is P cycles long, pulse covers its first width cycles.
  bit m_on      = 1'b0;
  bit m_started = 1'b0;
  int m_el      = 0;
  int m_w       = 1;
  int m_pos     = 0;

  initial forever @(posedge clk) begin
    if (!rst_n) begin
      m_on  = 1'b0;
      m_el  = 0;
      m_pos = 0;
    end else if (!m_on || m_el == P - 1) begin
      if (run) begin
        m_on  = 1'b1;
        m_el  = 0;
        m_pos = int'(pos);
        m_w   = exp_width(int'(pos));
      end else begin
        m_on = 1'b0;
      end
    end else begin
      m_el++;
    end
    m_started = 1'b1;
  end

  initial forever @(negedge clk) begin
    if (m_started) begin
      check("pwm",        int'(pwm),        int'(m_on && m_el < m_w));
      check("frame_tick", int'(frame_tick), int'(m_on && m_el == 0));
      check("busy",       int'(busy),       int'(m_on));
      check("pos_active", int'(pos_active), m_pos);
    end
  end

  // Observed pulse lengths, tick spacing and frame duration.
  int cyc = 0, hi_run = 0, last_pulse = -1, last_tick = -1, last_gap = -1;
  int last_busy_len = -1, tick_count = 0;
  bit prev_pwm = 1'b0, prev_busy = 1'b0;

  initial forever @(negedge clk) begin
    cyc++;
    if (pwm === 1'b1) hi_run++;
    else begin
      if (prev_pwm) last_pulse = hi_run;
      hi_run = 0;
    end
    if (frame_tick === 1'b1) begin
      if (last_tick >= 0) last_gap = cyc - last_tick;
      last_tick = cyc;
      tick_count++;
    end
    if (prev_busy && busy !== 1'b1) last_busy_len = cyc - last_tick;
    prev_pwm  = (pwm === 1'b1);
    prev_busy = (busy === 1'b1);
  end

  task automatic wait_tick(output int n);
    bit got;
    got = 1'b0;
    n   = 0;
    while (!got && n < 400) begin
      @(negedge clk);
      n++;
      if (frame_tick === 1'b1) got = 1'b1;
    end
    if (!got) timeout("wait_tick");
    #1;
  endtask

  task automatic wait_fall();
    int k;
    k = 0;
    while (pwm !== 1'b1 && k < 400) begin @(negedge clk); k++; end
    if (pwm !== 1'b1) timeout("wait_pwm_rise");
    k = 0;
    while (pwm !== 1'b0 && k < 400) begin @(negedge clk); k++; end
    if (pwm !== 1'b0) timeout("wait_pwm_fall");
    #1;
  endtask

  initial begin
    int n;
    int t0;
    rst_n = 1'b0;
    run   = 1'b0;
    pos   = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_pwm",        int'(pwm),        0);
    check("rst_busy",       int'(busy),       0);
    check("rst_tick",       int'(frame_tick), 0);
    check("rst_pos_active", int'(pos_active), 0);

    // pos=0: 10-cycle pulses, 200-cycle frames
    run   = 1'b1;
    rst_n = 1'b1;
    wait_tick(n);
    check("first_tick_latency", n, 1);
    wait_fall();
    check("pulse_pos0", last_pulse, 10);
    wait_tick(n);
    check("gap_pos0", last_gap, 200);
    check("pos_active_0", int'(pos_active), 0);

    // pos=15 clamps to 90
    pos = 4'd15;
    wait_tick(n);
    check("pos_active_15", int'(pos_active), 15);
    wait_fall();
    check("pulse_pos15", last_pulse, 90);

    // pos 4 -> 9 at cycle 5 of the frame
    pos = 4'd4;
    wait_tick(n);
    repeat (5) @(negedge clk);
    pos = 4'd9;
    wait_fall();
    check("pulse_pos4_kept", last_pulse, 34);
    wait_tick(n);
    check("pos_active_9", int'(pos_active), 9);
    wait_fall();
    check("pulse_pos9", last_pulse, 64);

    // back-to-back pos=7 frames
    pos = 4'd7;
    wait_tick(n);
    for (int i = 0; i < 3; i++) begin
      wait_fall();
      check("pulse_pos7", last_pulse, 52);
      wait_tick(n);
      check("gap_pos7", last_gap, 200);
    end

    // reset at cycle 5 of HIGH
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_pwm",        int'(pwm),        0);
    check("midrst_busy",       int'(busy),       0);
    check("midrst_pos_active", int'(pos_active), 0);
    rst_n = 1'b1;
    wait_tick(n);
    check("rerun_tick_latency", n, 1);
    wait_fall();
    check("rerun_pulse", last_pulse, 52);

    // run drops at cycle 50: frame completes, then idle
    wait_tick(n);
    repeat (50) @(negedge clk);
    run = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin @(negedge clk); n++; end
    if (busy !== 1'b0) timeout("wait_busy_fall");
    #1;
    check("stop_frame_len", last_busy_len, 200);
    t0 = tick_count;
    repeat (300) @(negedge clk);
    check("stop_no_tick", tick_count, t0);
    check("stop_pwm", int'(pwm), 0);
    check("stop_busy", int'(busy), 0);

    // randomized phase, checked every cycle by the model
    for (int it = 0; it < 60; it++) begin
      pos = 4'($urandom_range(0, 15));
      run = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 14) == 0) begin
        rst_n = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rst_n = 1'b1;
      end
      repeat ($urandom_range(1, 600)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
